dmem_arbiter: RTL

Two-requester arbiter and access sequencer for the single-port, byte-addressed, big-endian 1 KB data memory.
- Port 0 is the pipeline MEM stage; port 1 is the loader/debug port.
- The block grants one requester at a time using round-robin arbitration.
- It drives the memory's mem_read, mem_write, address and write_data for a configurable access latency, then returns read data and an ack.
- Misaligned or out-of-range word accesses are rejected with an error response and no memory side effect.

---
 rtl/dmem_arbiter_if.sv | 43 ++++
 rtl/dmem_arbiter.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter_if.sv
// Requester-side and memory-side signals of the data-memory arbiter.
// The arbiter uses the slave modport; requesters and the memory use master.
interface dmem_arbiter_if;
  logic        req0;
  logic        we0;
  logic [31:0] addr0;
  logic [31:0] wdata0;
  logic        ack0;
  logic        err0;
  logic [31:0] rdata0;

  logic        req1;
  logic        we1;
  logic [31:0] addr1;
  logic [31:0] wdata1;
  logic        ack1;
  logic        err1;
  logic [31:0] rdata1;

  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  modport slave (
    input  req0, we0, addr0, wdata0,
    output ack0, err0, rdata0,
    input  req1, we1, addr1, wdata1,
    output ack1, err1, rdata1,
    output mem_read, mem_write, mem_address, mem_write_data,
    input  mem_read_data
  );

  modport master (
    output req0, we0, addr0, wdata0,
    input  ack0, err0, rdata0,
    output req1, we1, addr1, wdata1,
    input  ack1, err1, rdata1,
    input  mem_read, mem_write, mem_address, mem_write_data,
    output mem_read_data
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin two-port arbiter and access sequencer for the 1 KB data memory.
// Define DMEM_ARB_STATS_EN to add saturating grant/error counters.
module dmem_arbiter #(
  parameter int MEM_BYTES   = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic             clk,
  input  logic             reset,
  dmem_arbiter_if.slave    bus
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [15:0]      gnt_cnt0,
  output logic [15:0]      gnt_cnt1,
  output logic [7:0]       err_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [31:0] ADDR_MAX  = 32'(MEM_BYTES - 4);
  localparam logic [2:0]  WAIT_LOAD = 3'(WAIT_CYCLES);

  state_t      state_q, state_d;
  logic        pref_q, pref_d;
  logic        port_q, port_d;
  logic        we_q, we_d;
  logic        err_q, err_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [2:0]  cnt_q, cnt_d;

  logic        grant;
  logic        gnt_port;
  logic        sel_we;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic        sel_err;
  logic        last_access;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pref_q  <= 1'b0;
      port_q  <= 1'b0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pref_q  <= pref_d;
      port_q  <= port_d;
      we_q    <= we_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
    end
  end

  // On contention the favoured port wins; otherwise whichever port asks.
  always_comb begin
    grant     = 1'b0;
    gnt_port  = 1'b0;
    if (bus.req0 || bus.req1) begin
      grant    = (state_q == IDLE);
      gnt_port = (bus.req0 && bus.req1) ? pref_q : bus.req1;
    end
    sel_we    = gnt_port ? bus.we1    : bus.we0;
    sel_addr  = gnt_port ? bus.addr1  : bus.addr0;
    sel_wdata = gnt_port ? bus.wdata1 : bus.wdata0;
    sel_err   = (sel_addr[1:0] != 2'b00) || (sel_addr > ADDR_MAX);
  end

  assign last_access = (state_q == ACCESS) && (cnt_q == 3'd0);

  always_comb begin
    state_d = state_q;
    pref_d  = pref_q;
    port_d  = port_q;
    we_d    = we_q;
    err_d   = err_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (grant) begin
          pref_d  = ~gnt_port;
          port_d  = gnt_port;
          we_d    = sel_we;
          addr_d  = sel_addr;
          wdata_d = sel_wdata;
          err_d   = sel_err;
          rdata_d = '0;
          cnt_d   = WAIT_LOAD;
          state_d = sel_err ? RESP : ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q == 3'd0) begin
          if (!we_q) rdata_d = bus.mem_read_data;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.ack0   = (state_q == RESP) && !port_q;
  assign bus.ack1   = (state_q == RESP) &&  port_q;
  assign bus.err0   = bus.ack0 && err_q;
  assign bus.err1   = bus.ack1 && err_q;
  assign bus.rdata0 = bus.ack0 ? rdata_q : '0;
  assign bus.rdata1 = bus.ack1 ? rdata_q : '0;

  // A write strobes only once so the memory commits a single word.
  assign bus.mem_read       = (state_q == ACCESS) && !we_q;
  assign bus.mem_write      = last_access && we_q;
  assign bus.mem_address    = (state_q == ACCESS) ? addr_q  : '0;
  assign bus.mem_write_data = (state_q == ACCESS) ? wdata_q : '0;

`ifdef DMEM_ARB_STATS_EN
  logic [15:0] gnt_cnt0_q;
  logic [15:0] gnt_cnt1_q;
  logic [7:0]  err_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gnt_cnt0_q <= '0;
      gnt_cnt1_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      if (grant && !gnt_port && (gnt_cnt0_q != 16'hFFFF)) gnt_cnt0_q <= gnt_cnt0_q + 16'd1;
      if (grant &&  gnt_port && (gnt_cnt1_q != 16'hFFFF)) gnt_cnt1_q <= gnt_cnt1_q + 16'd1;
      if ((state_q == RESP) && err_q && (err_cnt_q != 8'hFF)) err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign gnt_cnt0 = gnt_cnt0_q;
  assign gnt_cnt1 = gnt_cnt1_q;
  assign err_cnt  = err_cnt_q;
`endif

endmodule
